// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b.
// Each operation streams LSB-first through one full-adder slice
// (a + ~b + carry, with carry seeded to 1) over WIDTH cycles.
// Operands enter on a valid/ready handshake; the result leaves on another.
// Optional feature macro: FLAGS_EN. When it is defined, the zr/ng/ovf flags are
// computed and registered with diff. When it is undefined, they are tied to 0.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zr,
    output logic             ng,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_nxt;

    // One full-adder slice working on the current LSBs.
    assign w_sum     = r_sa[0] ^ r_sb[0] ^ r_carry;
    assign w_cout    = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
    assign w_res_nxt = {w_sum, r_res[WIDTH-1:1]};
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (r_cnt == LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand shift registers, carry, bit counter and the result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= a;
            r_sb    <= ~b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_carry <= w_cout;
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_res   <= w_res_nxt;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff   <= w_res_nxt;
                r_borrow <= ~w_cout;
            end
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;

`ifdef FLAGS_EN
    logic r_zr;
    logic r_ng;
    logic r_ovf;

    // Flags are captured with diff; on the last bit, r_carry is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zr  <= 1'b0;
            r_ng  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_zr  <= (w_res_nxt == '0);
            r_ng  <= w_sum;
            r_ovf <= r_carry ^ w_cout;
        end
    end

    assign zr  = r_zr;
    assign ng  = r_ng;
    assign ovf = r_ovf;
`else
    assign zr  = 1'b0;
    assign ng  = 1'b0;
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor (WIDTH=16) against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zr;
    logic         ng;
    logic         ovf;

    int n_cmp;
    int n_err;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zr        (zr),
        .ng        (ng),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one subtraction end to end.
    // It holds out_ready low for 'hold' DONE cycles and pokes in_valid once while doing so.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int hold);
        int w;
        int lat;
        int sd;
        logic [W-1:0] e_diff;
        logic e_bor, e_zr, e_ng, e_ovf;
        // Reference: plain arithmetic.
        e_diff = ta - tb_v;
        e_bor  = (ta < tb_v);
        sd     = int'($signed(ta)) - int'($signed(tb_v));
        e_ovf  = (sd > 32767) || (sd < -32768);
        e_zr   = (e_diff == 0);
        e_ng   = e_diff[W-1];
`ifndef FLAGS_EN
        e_zr = 1'b0; e_ng = 1'b0; e_ovf = 1'b0;
`endif
        w = 0;
        while (!in_ready && w < 40) begin tick(); w++; end
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb_v; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = '0; b = '0;
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk("latency", lat, W);
        chk("diff", {16'd0, diff}, {16'd0, e_diff});
        chk("borrow", {31'd0, borrow}, {31'd0, e_bor});
        chk("zr", {31'd0, zr}, {31'd0, e_zr});
        chk("ng", {31'd0, ng}, {31'd0, e_ng});
        chk("ovf", {31'd0, ovf}, {31'd0, e_ovf});
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin in_valid = 1'b1; a = 16'd9; b = 16'd1; end
            else in_valid = 1'b0;
            tick();
            chk("hold_diff", {16'd0, diff}, {16'd0, e_diff});
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", {31'd0, out_valid}, 32'd0);
        chk("ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst_n = 1'b1;
        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {16'd0, diff}, 32'd0);
        chk("rst_flags", {28'd0, borrow, zr, ng, ovf}, 32'd0);

        // Directed cases and boundaries
        run_op(16'd5, 16'd3, 0);
        run_op(16'd3, 16'd5, 0);
        run_op(16'h8000, 16'h0001, 1);
        run_op(16'h1234, 16'h1234, 0);
        run_op(16'h7FFF, 16'hFFFF, 0);
        run_op(16'hABCD, 16'h0000, 0);
        run_op(16'h0000, 16'h0001, 0);
        run_op(16'hFFFF, 16'hFFFF, 0);
        // Stalled consumer with a stray operand offered
        run_op(16'h4321, 16'h0123, 5);

        // Reset during RUN aborts the operation
        a = 16'd100; b = 16'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_diff", {16'd0, diff}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_borrow", {31'd0, borrow}, 32'd0);
        run_op(16'd7, 16'd2, 0);

        // Randomized operands and consumer stalls
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (k % 8 == 0) ? ra : W'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
